// File: rtl/radio_en_responder.sv
// radio_en_responder
// Radio-side end of the timing-engine enable protocol. Accepts the enable and
// RX requests, models PLL settle time and ramp-down time, returns pllSettled
// and flags protocol violations in a sticky error bit. All outputs are
// registered, so there is no combinational path from any input to any output.
//
// Handshake: there is no valid/ready pair. radioEnable is a level request that
// is honoured only after the PLL settles (pllSettled=1). radioRxEn is only
// meaningful while radioEnable is high. Once the enable drops, the block
// finishes its ramp-down and ignores requests until rampBusy falls.
module radio_en_responder #(
  parameter int SETTLE_CYC = 16,  // cycles from accepted enable to pllSettled (1..255)
  parameter int RAMPDN_CYC = 4    // cycles of ramp-down after enable drop (1..255)
) (
  input  logic       ck,
  input  logic       arst,
  input  logic       isolate,
  input  logic       radioEnable,
  input  logic       radioRxEn,
  input  logic       errClr,
  output logic       pllSettled,
  output logic       rxActive,
  output logic       rampBusy,
  output logic       protoErr,
  output logic [2:0] dbgState
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLING = 3'd1,
    S_SETTLED  = 3'd2,
    S_RX       = 3'd3,
    S_RAMPDN   = 3'd4
  } state_e;

  // Counter preload values; the counter runs down to zero inclusive, so a
  // phase lasting N cycles starts at N-1.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] RAMPDN_LOAD = 8'(RAMPDN_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pll_q, pll_d;
  logic       rxa_q, rxa_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  // Isolation clamps the view of the timing-engine domain before any
  // decision or check, so isolated inputs can never raise protoErr.
  logic en, rx;
  assign en = radioEnable & ~isolate;
  assign rx = radioRxEn & ~isolate;

  logic cnt_zero;
  assign cnt_zero = (cnt_q == 8'd0);

  // Next-state and counter logic for the enable/settle/ramp sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_SETTLING;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLING: begin
        // An enable drop wins even on the cycle the count expires.
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_zero) begin
          state_d = S_SETTLED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SETTLED: begin
        // Enable drop has priority over an RX request on the same edge.
        if (!en) begin
          state_d = S_RAMPDN;
          cnt_d   = RAMPDN_LOAD;
        end else if (rx) begin
          state_d = S_RX;
        end
      end
      S_RX: begin
        if (!en) begin
          state_d = S_RAMPDN;
          cnt_d   = RAMPDN_LOAD;
        end else if (!rx) begin
          state_d = S_SETTLED;
        end
      end
      S_RAMPDN: begin
        // Requests are ignored here; the ramp always runs to completion.
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Moore output decodes taken from the next state so the registered outputs
  // change on the same edge as the state itself.
  always_comb begin
    pll_d  = 1'b0;
    rxa_d  = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      S_SETTLED: pll_d  = 1'b1;
      S_RX: begin
        pll_d = 1'b1;
        rxa_d = 1'b1;
      end
      S_RAMPDN:  busy_d = 1'b1;
      default: begin
        pll_d  = 1'b0;
        rxa_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Sticky protocol-violation flag; a new violation beats a clear.
  logic viol;
  always_comb begin
    viol = 1'b0;
    if (rx && !en)                     viol = 1'b1;
    if (state_q == S_SETTLING && rx)   viol = 1'b1;
    if (state_q == S_RAMPDN && en)     viol = 1'b1;
    err_d = err_q;
    if (viol)        err_d = 1'b1;
    else if (errClr) err_d = 1'b0;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge ck) begin
    if (arst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      pll_q   <= 1'b0;
      rxa_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pll_q   <= pll_d;
      rxa_q   <= rxa_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pllSettled = pll_q;
  assign rxActive   = rxa_q;
  assign rampBusy   = busy_q;
  assign protoErr   = err_q;
  assign dbgState   = state_q;

endmodule

// File: tb/tb_radio_en_responder.sv
// tb_radio_en_responder
// Directed bench for radio_en_responder. A phase/age model computes the
// expected outputs each edge; a negedge process compares the DUT against it,
// and literal expectations at hand-picked edges pin both DUT and model.
// Edge numbers are counted from the reset edge (edge 0) of each scenario.
module tb_radio_en_responder;

  localparam int SETTLE = 16;
  localparam int RAMPDN = 4;

  // clock / reset
  logic ck = 1'b0;
  logic arst = 1'b0;
  logic isolate = 1'b0;
  logic radioEnable = 1'b0;
  logic radioRxEn = 1'b0;
  logic errClr = 1'b0;
  logic pllSettled, rxActive, rampBusy, protoErr;
  logic [2:0] dbgState;

  always #5 ck = ~ck;

  radio_en_responder #(.SETTLE_CYC(SETTLE), .RAMPDN_CYC(RAMPDN)) dut (
    .ck(ck), .arst(arst), .isolate(isolate), .radioEnable(radioEnable),
    .radioRxEn(radioRxEn), .errClr(errClr), .pllSettled(pllSettled),
    .rxActive(rxActive), .rampBusy(rampBusy), .protoErr(protoErr),
    .dbgState(dbgState)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  // model: phase of the protocol plus the number of edges spent in it
  localparam int P_IDLE = 0, P_SETTLE = 1, P_ON = 2, P_RAMP = 3;
  int m_phase = P_IDLE;
  int m_age = 0;
  bit m_rxon = 1'b0;
  bit m_err = 1'b0;
  bit model_valid = 1'b0;

  always @(posedge ck) begin
    bit en, rx, eset;
    cyc = cyc + 1;
    en = radioEnable && !isolate;
    rx = radioRxEn && !isolate;
    if (arst) begin
      m_phase = P_IDLE; m_age = 0; m_rxon = 1'b0; m_err = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      eset = (rx && !en) || (m_phase == P_SETTLE && rx) || (m_phase == P_RAMP && en);
      if (eset) m_err = 1'b1;
      else if (errClr) m_err = 1'b0;
      case (m_phase)
        P_IDLE: if (en) begin m_phase = P_SETTLE; m_age = 1; end
        P_SETTLE: begin
          if (!en) m_phase = P_IDLE;
          else if (m_age == SETTLE) begin m_phase = P_ON; m_rxon = rx; end
          else m_age = m_age + 1;
        end
        P_ON: begin
          if (!en) begin m_phase = P_RAMP; m_age = 1; m_rxon = 1'b0; end
          else m_rxon = rx;
        end
        default: begin
          if (m_age == RAMPDN) m_phase = P_IDLE;
          else m_age = m_age + 1;
        end
      endcase
    end
  end

  function automatic bit exp_pll();  return m_phase == P_ON; endfunction
  function automatic bit exp_rxa();  return m_phase == P_ON && m_rxon; endfunction
  function automatic bit exp_busy(); return m_phase == P_RAMP; endfunction

  // scoreboard comparison
  task automatic cmp(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s edge=%0d actual=%b expected=%b state=%0d",
               name, cyc - base, act, exp, dbgState);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge ck) begin
    if (model_valid) begin
      cmp("pllSettled", pllSettled, exp_pll());
      cmp("rxActive", rxActive, exp_rxa());
      cmp("rampBusy", rampBusy, exp_busy());
      cmp("protoErr", protoErr, m_err);
    end
  end

  // hand-computed literal expectations, applied to DUT and model alike
  task automatic lit(input string tag, input bit p, input bit r, input bit b, input bit e);
    cmp({tag, ".pll"}, pllSettled, p);
    cmp({tag, ".rxa"}, rxActive, r);
    cmp({tag, ".busy"}, rampBusy, b);
    cmp({tag, ".err"}, protoErr, e);
    cmp({tag, ".model_pll"}, exp_pll(), p);
    cmp({tag, ".model_rxa"}, exp_rxa(), r);
    cmp({tag, ".model_busy"}, exp_busy(), b);
    cmp({tag, ".model_err"}, m_err, e);
  endtask

  // driver tasks: go(n) returns 1 time unit after edge n; inputs set then
  // are sampled at edge n+1
  task automatic go(input int n);
    if (cyc > base + n) begin
      errors = errors + 1;
      $display("FAIL sequencing target=%0d now=%0d", n, cyc - base);
    end
    while (cyc < base + n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic do_reset();
    isolate = 1'b0; radioEnable = 1'b0; radioRxEn = 1'b0; errClr = 1'b0;
    arst = 1'b1;
    @(posedge ck);
    #1;
    base = cyc;
    arst = 1'b0;
  endtask

  initial begin
    // settle, RX, ramp-down with early re-enable
    do_reset();
    lit("reset", 0, 0, 0, 0);
    go(9);  radioEnable = 1'b1;
    go(25); lit("settle_e25", 0, 0, 0, 0);
    go(26); lit("settle_e26", 1, 0, 0, 0);
    go(39); radioRxEn = 1'b1;
    go(40); lit("rx_e40", 1, 1, 0, 0);
    go(49); lit("rx_e49", 1, 1, 0, 0);
    radioRxEn = 1'b0;
    go(50); lit("rx_e50", 1, 0, 0, 0);
    go(54); radioRxEn = 1'b1;
    go(55); lit("rx_e55", 1, 1, 0, 0);
    go(59); radioEnable = 1'b0; radioRxEn = 1'b0;
    go(60); lit("ramp_e60", 0, 0, 1, 0);
    go(61); radioEnable = 1'b1;
    go(62); lit("reen_e62", 0, 0, 1, 1);
    go(63); lit("ramp_e63", 0, 0, 1, 1);
    go(64); lit("ramp_e64", 0, 0, 0, 1);
    go(80); lit("resettle_e80", 0, 0, 0, 1);
    go(81); lit("resettle_e81", 1, 0, 0, 1);
    errClr = 1'b1;
    go(82); errClr = 1'b0; lit("clr_e82", 1, 0, 0, 0);

    // isolate during SETTLING aborts; RX while isolated is not an error
    do_reset();
    go(4);  radioEnable = 1'b1;
    go(11); isolate = 1'b1;
    go(12); lit("iso_abort_e12", 0, 0, 0, 0);
    go(21); lit("iso_abort_e21", 0, 0, 0, 0);
    go(22); radioRxEn = 1'b1;
    go(25); lit("iso_rx_e25", 0, 0, 0, 0);
    go(26); radioRxEn = 1'b0; radioEnable = 1'b0; isolate = 1'b0;

    // isolate in SETTLED behaves like an enable drop
    do_reset();
    go(1);  radioEnable = 1'b1;
    go(18); lit("iso_settled_e18", 1, 0, 0, 0);
    go(19); isolate = 1'b1;
    go(20); lit("iso_ramp_e20", 0, 0, 1, 0);
    go(23); lit("iso_ramp_e23", 0, 0, 1, 0);
    go(24); lit("iso_ramp_e24", 0, 0, 0, 0);
    go(26); lit("iso_hold_e26", 0, 0, 0, 0);
    isolate = 1'b0; radioEnable = 1'b0;

    // protoErr set, clear, and set-beats-clear
    do_reset();
    go(2);  radioRxEn = 1'b1;
    go(3);  lit("err_e3", 0, 0, 0, 1);
    radioRxEn = 1'b0;
    go(7);  errClr = 1'b1;
    go(8);  lit("clr_e8", 0, 0, 0, 0);
    radioRxEn = 1'b1;
    go(9);  lit("setwins_e9", 0, 0, 0, 1);
    errClr = 1'b0; radioRxEn = 1'b0;
    go(10); lit("sticky_e10", 0, 0, 0, 1);

    // reset pulse mid-SETTLING restarts the settle
    do_reset();
    go(9);  radioEnable = 1'b1;
    go(19); arst = 1'b1;
    go(20); arst = 1'b0; lit("rst_mid_e20", 0, 0, 0, 0);
    go(36); lit("rst_mid_e36", 0, 0, 0, 0);
    go(37); lit("rst_mid_e37", 1, 0, 0, 0);

    // enable drop and RX rise together: drop wins; then reset mid-ramp
    do_reset();
    go(1);  radioEnable = 1'b1;
    go(18); lit("simul_e18", 1, 0, 0, 0);
    go(19); radioEnable = 1'b0; radioRxEn = 1'b1;
    go(20); lit("simul_e20", 0, 0, 1, 1);
    radioRxEn = 1'b0;
    go(21); arst = 1'b1;
    go(22); arst = 1'b0; lit("rst_ramp_e22", 0, 0, 0, 0);

    // enable drops on the edge the settle count would complete
    do_reset();
    go(0);  radioEnable = 1'b1;
    go(16); lit("late_drop_e16", 0, 0, 0, 0);
    radioEnable = 1'b0;
    go(17); lit("late_drop_e17", 0, 0, 0, 0);
    go(20); lit("late_drop_e20", 0, 0, 0, 0);

    @(negedge ck);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    errors = errors + 1;
    $display("FAIL watchdog edge=%0d", cyc - base);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/radio_en_responder.md
# radio_en_responder

Radio-side responder for the timing-engine enable protocol: consumes `radioEnable` / `radioRxEn` from the timing engine and returns `pllSettled`, modelling PLL settle and ramp-down and reporting protocol violations. Sits at the far end of the timing-engine interface, in the radio power domain, with an isolation input clamping its view of the timing-engine domain.

## Interface
- `SETTLE_CYC`, 16: cycles from accepted enable to `pllSettled`; legal range 1..255.
- `RAMPDN_CYC`, 4: cycles of ramp-down after enable drop; legal range 1..255.

- `ck`  in  1  clock; all flops on rising edge.
- `arst`  in  1  reset, synchronous, active-high.
- `isolate`  in  1  clamp; when 1, `radioEnable` and `radioRxEn` are treated as 0.
- `radioEnable`  in  1  enable request from the timing engine.
- `radioRxEn`  in  1  RX request from the timing engine; valid only while `radioEnable`=1.
- `errClr`  in  1  single-cycle clear of `protoErr`.
- `pllSettled`  out  1  PLL locked; drives timing engine `pllSettled`.
- `rxActive`  out  1  receiver on.
- `rampBusy`  out  1  ramp-down in progress; enable requests ignored.
- `protoErr`  out  1  sticky protocol-violation flag.

## Operation
- Effective inputs: `en = radioEnable & ~isolate`, `rx = radioRxEn & ~isolate`.
- Single down-counter `cnt`, 8 bits. All outputs are registered Moore decodes updated on the same edge as the state.
- States and transitions, evaluated each edge:
  - IDLE: if `en`, go to SETTLING and load `cnt = SETTLE_CYC-1`.
  - SETTLING: if `!en`, abort to IDLE with `cnt=0`. Else if `cnt==0`, go to SETTLED. Else decrement `cnt`.
  - SETTLED: if `!en`, go to RAMPDN and load `cnt = RAMPDN_CYC-1`. Else if `rx`, go to RX.
  - RX: if `!en`, go to RAMPDN and load `cnt = RAMPDN_CYC-1`. Else if `!rx`, go to SETTLED.
  - RAMPDN: `en` and `rx` are ignored. If `cnt==0`, go to IDLE. Else decrement `cnt`.
- Outputs by state:
  - `pllSettled` = 1 in SETTLED or RX.
  - `rxActive` = 1 in RX.
  - `rampBusy` = 1 in RAMPDN.
- `protoErr` is set on any edge where:
  - `rx & ~en`, or
  - `rx` in SETTLING, or
  - `en` in RAMPDN (re-enable before ramp-down completes).
- `protoErr` clears on `errClr`. Set has priority over clear when both occur in the same cycle.
- Isolated inputs never set `protoErr`, because gating happens before any check.
- Asserting `isolate` mid-operation behaves exactly like `en` falling: SETTLING aborts to IDLE; SETTLED and RX go to RAMPDN.

## Timing
- Reset: state IDLE, `cnt=0`, and all outputs 0 (`pllSettled`, `rxActive`, `rampBusy`, `protoErr`). Reset overrides all inputs, including mid-SETTLING and mid-RAMPDN.
- `en` first sampled high at edge k:
  - SETTLING from edge k.
  - `pllSettled`=1 after edge k+SETTLE_CYC.
  - `SETTLE_CYC=1` gives one SETTLING cycle.
- `rx` sampled high in SETTLED at edge m: `rxActive`=1 after edge m. `rx` low at edge n: `rxActive`=0 after edge n.
- `en` sampled low in SETTLED or RX at edge d:
  - `pllSettled` and `rxActive` go to 0 and `rampBusy` goes to 1, all after edge d.
  - `rampBusy`=0 after edge d+RAMPDN_CYC.
  - IDLE is entered at the same edge.
  - An `en` held high at edge d+RAMPDN_CYC is first accepted at edge d+RAMPDN_CYC+1.
- Simultaneous `en` fall and `rx` rise: the enable drop wins and the block goes to RAMPDN.
- `en` dropping on the same edge that `cnt` reaches 0 in SETTLING: abort to IDLE; `pllSettled` never rises.
- No combinational path from any input to any output.

## Test plan
- Reset, then `radioEnable`=1 at edge 10 (SETTLE_CYC=16) → `pllSettled` rises after edge 26; `rampBusy` and `protoErr` stay 0 throughout.
- Settled; `radioRxEn`=1 at edge 40 and 0 at edge 50 → `rxActive` high after edge 40 through edge 49, low after edge 50; `pllSettled` stays 1.
- In RX, `radioEnable` drops at edge 60 (RAMPDN_CYC=4) → `pllSettled`=`rxActive`=0 after edge 60; `rampBusy` high after edges 60–63, low after edge 64.
  - Re-enable at edge 62 → `protoErr`=1 after edge 62.
  - With `en` still high at edge 64, settling restarts at edge 65.
- Enable at edge 5; assert `isolate` at edge 12 → abort to IDLE, `pllSettled` never rises, `protoErr` stays 0. Drive `radioRxEn`=1 while isolated → `protoErr` stays 0.
- `radioRxEn`=1 with `radioEnable`=0 at edge 3 → `protoErr`=1 after edge 3. `errClr` at edge 8 → 0 after edge 8. `errClr` together with a violation at edge 9 → `protoErr` stays 1.
- `arst` pulsed for one cycle at edge 20, mid-SETTLING with `en` high → all outputs 0 after edge 20, `pllSettled` rises after edge 20+1+16=37.
